// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: memory op codes, FSM states, bus widths
// and lane-select helpers.
package mem_wb_stage_pkg;

    localparam int   REG_BUS_W     = 32;
    localparam int   REG_ADDR_W    = 5;
    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [3:0] {
        OP_ALU = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Big-endian lane select: bit 3 is byte offset 0; halfword uses offset[1] only.
    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b1000 >> off;
            OP_LH, OP_LHU, OP_SH: return off[1] ? 4'b0011 : 4'b1100;
            OP_LW, OP_SW:         return 4'b1111;
            default:              return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational big-endian load extraction: picks the byte/halfword lane and
// sign- or zero-extends it to a full register word.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [3:0]           op,
    input  logic [1:0]           offset,
    input  logic [REG_BUS_W-1:0] rdata,
    output logic [REG_BUS_W-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction: offset 0 is the most significant byte
    always_comb begin
        byte_s = 8'h00;
        case (offset)
            2'd0:    byte_s = rdata[31:24];
            2'd1:    byte_s = rdata[23:16];
            2'd2:    byte_s = rdata[15:8];
            2'd3:    byte_s = rdata[7:0];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[15:0];
        end else begin
            half_s = rdata[31:16];
        end
    end

    // Width extension according to the load flavour
    always_comb begin
        data = rdata;
        case (op)
            OP_LB:   data = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  data = {24'h000000, byte_s};
            OP_LH:   data = {{16{half_s[15]}}, half_s};
            OP_LHU:  data = {16'h0000, half_s};
            OP_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register with req/ack data-memory handshake.
// Optional macro MEM_ALIGN_EXC_EN adds excp_align_o and suppresses misaligned accesses.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int                   DM_SEL_W   = 4,
    parameter logic [REG_BUS_W-1:0] RESULT_RST = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  mem_wreg_i,
    input  logic [REG_ADDR_W-1:0] mem_wd_i,
    input  logic [REG_BUS_W-1:0]  mem_wdata_i,
    input  logic [3:0]            mem_op_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [REG_BUS_W-1:0]  mem_sdata_i,
    output logic                  dm_req_o,
    output logic                  dm_we_o,
    output logic [31:0]           dm_addr_o,
    output logic [DM_SEL_W-1:0]   dm_sel_o,
    output logic [REG_BUS_W-1:0]  dm_wdata_o,
    input  logic [REG_BUS_W-1:0]  dm_rdata_i,
    input  logic                  dm_ack_i,
    output logic                  fwd_wreg_o,
    output logic [REG_ADDR_W-1:0] fwd_wd_o,
    output logic [REG_BUS_W-1:0]  fwd_wdata_o,
    output logic                  stallreq_o,
    output logic                  wb_wreg_o,
    output logic [REG_ADDR_W-1:0] wb_wd_o,
    output logic [REG_BUS_W-1:0]  wb_wdata_o
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic                  excp_align_o
`endif
);

    mem_state_e            state_r;
    logic                  misalign_s;
    logic                  is_load_s;
    logic                  is_store_s;
    logic                  mem_op_s;
    logic                  stallreq_s;
    logic [DM_SEL_W-1:0]   sel_s;
    logic [REG_BUS_W-1:0]  sdata_s;
    logic [REG_BUS_W-1:0]  aligned_s;
    logic [REG_BUS_W-1:0]  hold_data_r;
    logic [29:0]           req_addr_r;
    logic [DM_SEL_W-1:0]   req_sel_r;
    logic [REG_BUS_W-1:0]  req_wdata_r;
    logic                  req_we_r;

`ifdef MEM_ALIGN_EXC_EN
    logic                  excp_r;

    // Misalignment detection for halfword and word accesses
    always_comb begin
        misalign_s = 1'b0;
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: misalign_s = mem_addr_i[0];
            OP_LW, OP_SW:         misalign_s = |mem_addr_i[1:0];
            default:              misalign_s = 1'b0;
        endcase
    end

    // Exception pulse registered as the offending instruction enters WB
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            excp_r <= 1'b0;
        end else if (flush_i || stall_i) begin
            excp_r <= 1'b0;
        end else begin
            excp_r <= misalign_s;
        end
    end

    assign excp_align_o = excp_r;
`else
    // Low address bits below the access size are ignored by lane_sel and load_align
    assign misalign_s = 1'b0;
`endif

    assign is_load_s  = is_load(mem_op_i) & ~misalign_s;
    assign is_store_s = is_store(mem_op_i) & ~misalign_s;
    assign mem_op_s   = is_load_s | is_store_s;
    assign sel_s      = DM_SEL_W'(lane_sel(mem_op_i, mem_addr_i[1:0]));

    // A stall is needed whenever an access is in flight without its acknowledge
    assign stallreq_s = (((state_r == ST_IDLE) && mem_op_s) || (state_r == ST_WAIT)) && !dm_ack_i;
    assign stallreq_o = stallreq_s;

    mem_wb_stage_load_align u_load_align (
        .op     (mem_op_i),
        .offset (mem_addr_i[1:0]),
        .rdata  (dm_rdata_i),
        .data   (aligned_s)
    );

    // Store data replicated into every lane the select may enable
    always_comb begin
        sdata_s = 32'h0;
        case (mem_op_i)
            OP_SB:   sdata_s = {4{mem_sdata_i[7:0]}};
            OP_SH:   sdata_s = {2{mem_sdata_i[15:0]}};
            OP_SW:   sdata_s = mem_sdata_i;
            default: sdata_s = 32'h0;
        endcase
    end

    // Data-memory port: live request in IDLE, captured request replayed in WAIT
    always_comb begin
        dm_req_o   = 1'b0;
        dm_we_o    = 1'b0;
        dm_addr_o  = {mem_addr_i[31:2], 2'b00};
        dm_sel_o   = '0;
        dm_wdata_o = 32'h0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    dm_req_o   = 1'b1;
                    dm_we_o    = is_store_s;
                    dm_sel_o   = sel_s;
                    dm_wdata_o = sdata_s;
                end else begin
                    dm_req_o   = 1'b0;
                    dm_we_o    = 1'b0;
                end
            end
            ST_WAIT: begin
                dm_req_o   = 1'b1;
                dm_we_o    = req_we_r;
                dm_addr_o  = {req_addr_r, 2'b00};
                dm_sel_o   = req_sel_r;
                dm_wdata_o = req_wdata_r;
            end
            ST_HOLD: dm_req_o = 1'b0;
            default: dm_req_o = 1'b0;
        endcase
    end

    // Forwarding values: loads are only valid once data is acknowledged or held
    always_comb begin
        fwd_wreg_o  = mem_wreg_i;
        fwd_wd_o    = mem_wd_i;
        fwd_wdata_o = mem_wdata_i;
        if (is_store_s || misalign_s) begin
            fwd_wreg_o = WRITE_DISABLE;
        end else if (is_load_s) begin
            if (state_r == ST_HOLD) begin
                fwd_wdata_o = hold_data_r;
            end else if (dm_ack_i) begin
                fwd_wdata_o = aligned_s;
            end else begin
                fwd_wreg_o  = WRITE_DISABLE;
                fwd_wdata_o = aligned_s;
            end
        end else begin
            fwd_wreg_o = mem_wreg_i;
        end
    end

    // Handshake FSM with request capture and held load result
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r     <= ST_IDLE;
            hold_data_r <= 32'h0;
            req_addr_r  <= 30'h0;
            req_sel_r   <= '0;
            req_wdata_r <= 32'h0;
            req_we_r    <= 1'b0;
        end else if (flush_i) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s) begin
                        if (dm_ack_i) begin
                            if (stall_i) begin
                                state_r     <= ST_HOLD;
                                hold_data_r <= aligned_s;
                            end
                        end else begin
                            state_r     <= ST_WAIT;
                            req_addr_r  <= mem_addr_i[31:2];
                            req_sel_r   <= sel_s;
                            req_wdata_r <= sdata_s;
                            req_we_r    <= is_store_s;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dm_ack_i) begin
                        if (stall_i) begin
                            state_r     <= ST_HOLD;
                            hold_data_r <= aligned_s;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB register; an outstanding access retires a bubble so WB never repeats
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wb_wreg_o  <= WRITE_DISABLE;
            wb_wd_o    <= 5'd0;
            wb_wdata_o <= RESULT_RST;
        end else if (flush_i || stallreq_s) begin
            wb_wreg_o  <= WRITE_DISABLE;
            wb_wd_o    <= 5'd0;
            wb_wdata_o <= RESULT_RST;
        end else if (!stall_i) begin
            wb_wreg_o  <= (fwd_wreg_o == WRITE_ENABLE);
            wb_wd_o    <= fwd_wd_o;
            wb_wdata_o <= fwd_wdata_o;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (default build, no alignment exception).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        mem_wreg_i = 1'b0;
    logic [4:0]  mem_wd_i = 5'd0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic [3:0]  mem_op_i = 4'd0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_sdata_i = 32'h0;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_sel_o;
    logic [31:0] dm_wdata_o;
    logic [31:0] dm_rdata_i = 32'h0;
    logic        dm_ack_i = 1'b0;
    logic        fwd_wreg_o;
    logic [4:0]  fwd_wd_o;
    logic [31:0] fwd_wdata_o;
    logic        stallreq_o;
    logic        wb_wreg_o;
    logic [4:0]  wb_wd_o;
    logic [31:0] wb_wdata_o;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;

    mem_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .mem_wreg_i  (mem_wreg_i),
        .mem_wd_i    (mem_wd_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sdata_i (mem_sdata_i),
        .dm_req_o    (dm_req_o),
        .dm_we_o     (dm_we_o),
        .dm_addr_o   (dm_addr_o),
        .dm_sel_o    (dm_sel_o),
        .dm_wdata_o  (dm_wdata_o),
        .dm_rdata_i  (dm_rdata_i),
        .dm_ack_i    (dm_ack_i),
        .fwd_wreg_o  (fwd_wreg_o),
        .fwd_wd_o    (fwd_wd_o),
        .fwd_wdata_o (fwd_wdata_o),
        .stallreq_o  (stallreq_o),
        .wb_wreg_o   (wb_wreg_o),
        .wb_wd_o     (wb_wd_o),
        .wb_wdata_o  (wb_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic wreg, input logic [4:0] wd,
                         input logic [31:0] wdata, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic ack, input logic [31:0] rdata);
        mem_op_i    = op;
        mem_wreg_i  = wreg;
        mem_wd_i    = wd;
        mem_wdata_i = wdata;
        mem_addr_i  = addr;
        mem_sdata_i = sdata;
        dm_ack_i    = ack;
        dm_rdata_i  = rdata;
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic wreg, input logic [4:0] wd, input logic [31:0] wdata);
        chk({tag, ".wb_wreg"},  32'(wb_wreg_o),  32'(wreg));
        chk({tag, ".wb_wd"},    32'(wb_wd_o),    32'(wd));
        chk({tag, ".wb_wdata"}, wb_wdata_o, wdata);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_wb("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.dm_req", 32'(dm_req_o), 32'd0);
        chk("reset.stallreq", 32'(stallreq_o), 32'd0);

        // ALU pass-through
        drive(4'd0, 1'b1, 5'd5, 32'h1234, 32'h0000_0100, 32'h0, 1'b0, 32'h0);
        chk("alu.fwd_wreg", 32'(fwd_wreg_o), 32'd1);
        chk("alu.fwd_wd", 32'(fwd_wd_o), 32'd5);
        chk("alu.fwd_wdata", fwd_wdata_o, 32'h1234);
        chk("alu.dm_req", 32'(dm_req_o), 32'd0);
        tick();
        chk_wb("alu", 1'b1, 5'd5, 32'h1234);

        // Unknown op acts as ALU and never requests memory
        drive(4'd12, 1'b1, 5'd6, 32'h0000_00AA, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        chk("unk.dm_req", 32'(dm_req_o), 32'd0);
        chk("unk.stallreq", 32'(stallreq_o), 32'd0);
        tick();
        chk_wb("unk", 1'b1, 5'd6, 32'h0000_00AA);

        // LB / LBU at 0x101 with same-cycle ack
        drive(4'd1, 1'b1, 5'd7, 32'hDEAD, 32'h0000_0101, 32'h0, 1'b1, 32'h1180_2233);
        chk("lb.dm_req", 32'(dm_req_o), 32'd1);
        chk("lb.dm_we", 32'(dm_we_o), 32'd0);
        chk("lb.dm_addr", dm_addr_o, 32'h0000_0100);
        chk("lb.dm_sel", 32'(dm_sel_o), 32'h4);
        chk("lb.stallreq", 32'(stallreq_o), 32'd0);
        tick();
        chk_wb("lb", 1'b1, 5'd7, 32'hFFFF_FF80);
        drive(4'd2, 1'b1, 5'd7, 32'hDEAD, 32'h0000_0101, 32'h0, 1'b1, 32'h1180_2233);
        chk("lbu.fwd_wdata", fwd_wdata_o, 32'h0000_0080);
        tick();
        chk_wb("lbu", 1'b1, 5'd7, 32'h0000_0080);

        // LHU with odd address: addr[0] ignored, upper half zero-extended
        drive(4'd4, 1'b1, 5'd2, 32'h0, 32'h0000_0201, 32'h0, 1'b1, 32'h8001_1234);
        chk("lhu.dm_sel", 32'(dm_sel_o), 32'hC);
        tick();
        chk_wb("lhu", 1'b1, 5'd2, 32'h0000_8001);

        // LW at 0x200 acknowledged after 3 cycles
        drive(4'd5, 1'b1, 5'd9, 32'h0, 32'h0000_0200, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (stallreq_o === 1'b1) stall_cycles++;
            chk("lw.dm_req", 32'(dm_req_o), 32'd1);
            chk("lw.dm_addr", dm_addr_o, 32'h0000_0200);
            chk("lw.dm_sel", 32'(dm_sel_o), 32'hF);
            chk("lw.fwd_wreg", 32'(fwd_wreg_o), 32'd0);
            tick();
            chk_wb("lw.bubble", 1'b0, 5'd0, 32'h0);
        end
        chk("lw.stall_cycles", 32'(stall_cycles), 32'd3);
        drive(4'd5, 1'b1, 5'd9, 32'h0, 32'h0000_0200, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("lw.ack_stallreq", 32'(stallreq_o), 32'd0);
        chk("lw.ack_fwd_wdata", fwd_wdata_o, 32'hDEAD_BEEF);
        tick();
        chk_wb("lw.done", 1'b1, 5'd9, 32'hDEAD_BEEF);
        drive(4'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("lw.after_dm_req", 32'(dm_req_o), 32'd0);
        tick();
        chk("lw.once", 32'(wb_wreg_o), 32'd0);

        // SH at 0x102
        drive(4'd7, 1'b1, 5'd4, 32'h0, 32'h0000_0102, 32'h0000_ABCD, 1'b1, 32'h0);
        chk("sh.dm_sel", 32'(dm_sel_o), 32'h3);
        chk("sh.dm_wdata", dm_wdata_o, 32'hABCD_ABCD);
        chk("sh.dm_we", 32'(dm_we_o), 32'd1);
        chk("sh.fwd_wreg", 32'(fwd_wreg_o), 32'd0);
        tick();
        chk_wb("sh", 1'b0, 5'd4, 32'h0);

        // SB at 0x103
        drive(4'd6, 1'b1, 5'd4, 32'h0, 32'h0000_0103, 32'h1234_565A, 1'b1, 32'h0);
        chk("sb.dm_sel", 32'(dm_sel_o), 32'h1);
        chk("sb.dm_wdata", dm_wdata_o, 32'h5A5A_5A5A);
        tick();

        // LH acknowledged while WB is stalled for 2 cycles
        stall_i = 1'b1;
        drive(4'd3, 1'b1, 5'd3, 32'h0, 32'h0000_0202, 32'h0, 1'b1, 32'h1234_8001);
        chk("lh.dm_req", 32'(dm_req_o), 32'd1);
        chk("lh.stallreq", 32'(stallreq_o), 32'd0);
        tick();
        drive(4'd3, 1'b1, 5'd3, 32'h0, 32'h0000_0202, 32'h0, 1'b0, 32'h0);
        chk("lh.hold_dm_req", 32'(dm_req_o), 32'd0);
        chk("lh.hold_stallreq", 32'(stallreq_o), 32'd0);
        chk("lh.hold_fwd_wdata", fwd_wdata_o, 32'hFFFF_8001);
        chk_wb("lh.held", 1'b0, 5'd4, 32'h0);
        tick();
        stall_i = 1'b0;
        #1;
        chk("lh.release_dm_req", 32'(dm_req_o), 32'd0);
        chk("lh.release_fwd_wreg", 32'(fwd_wreg_o), 32'd1);
        tick();
        chk_wb("lh", 1'b1, 5'd3, 32'hFFFF_8001);

        // Flush on an ALU op inserts a bubble
        flush_i = 1'b1;
        drive(4'd0, 1'b1, 5'd11, 32'h0000_0077, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        chk_wb("flush.alu", 1'b0, 5'd0, 32'h0);
        flush_i = 1'b0;

        // Flush during WAIT abandons the request
        drive(4'd5, 1'b1, 5'd6, 32'h0, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
        tick();
        chk("flush.wait_stallreq", 32'(stallreq_o), 32'd1);
        flush_i = 1'b1;
        #1;
        tick();
        flush_i = 1'b0;
        chk_wb("flush.wait", 1'b0, 5'd0, 32'h0);
        drive(4'd0, 1'b1, 5'd10, 32'h0000_00A5, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("flush.idle_dm_req", 32'(dm_req_o), 32'd0);
        chk("flush.idle_stallreq", 32'(stallreq_o), 32'd0);
        tick();
        chk_wb("flush.next", 1'b1, 5'd10, 32'h0000_00A5);

        // Reset during WAIT
        drive(4'd5, 1'b1, 5'd8, 32'h0, 32'h0000_0400, 32'h0, 1'b0, 32'h0);
        tick();
        chk("rst.wait_dm_req", 32'(dm_req_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(4'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk_wb("rst.mid", 1'b0, 5'd0, 32'h0);
        chk("rst.idle_dm_req", 32'(dm_req_o), 32'd0);
        chk("rst.idle_stallreq", 32'(stallreq_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
